// File: rtl/svt_frame_pkg.sv
// Shared types and line levels for the svt serial frame link.
// Imported by both the receiver and the transmitter.
package svt_frame_pkg;

    localparam int PKG_DATA_W = 4;

    typedef logic [PKG_DATA_W-1:0] uint_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Outcome of a completed frame, resolved on the stop-bit sample.
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_PUSH = 2'd1,
        RES_PERR = 2'd2,
        RES_FERR = 2'd3
    } rx_res_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/svt_frame_obuf.sv
// One-entry valid/ready holding register for received payloads.
// Flags an overrun when a push arrives while the held word cannot leave.
module svt_frame_obuf
    import svt_frame_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              ovr_q;
    logic              ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (push_i) begin
            if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = data_i;
                valid_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/svt_frame_rx.sv
// Bit-serial frame receiver: start, LSB-first data, optional parity, stop.
// Good frames land in a 1-entry buffer; errors are reported as pulses.
module svt_frame_rx
    import svt_frame_pkg::*;
#(
    parameter int DATA_W     = PKG_DATA_W,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rxd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frame_err,
    output logic              overrun,
    output rx_state_t         state_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              par_q;
    rx_res_t           res_q;
    logic              perr_q;
    logic              ferr_q;
    logic              par_bad;

    assign par_bad = PARITY_EN &&
                     (((^shreg_q) ^ par_q ^ PARITY_ODD) != 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            res_q   <= RES_NONE;
        end else begin
            res_q <= RES_NONE;
            if (bit_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (rxd == START_LVL) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        shreg_q[cnt_q] <= rxd;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= PARITY_EN ? PARITY : STOP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_q   <= rxd;
                        state_q <= STOP;
                    end
                    STOP: begin
                        // The stop bit never doubles as the next start bit.
                        state_q <= IDLE;
                        if (rxd != STOP_LVL) begin
                            res_q <= RES_FERR;
                        end else if (par_bad) begin
                            res_q <= RES_PERR;
                        end else begin
                            res_q <= RES_PUSH;
                        end
                    end
                endcase
            end
        end
    end

    // Error pulses share the buffer's one-cycle load latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            perr_q <= (res_q == RES_PERR);
            ferr_q <= (res_q == RES_FERR);
        end
    end

    svt_frame_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (res_q == RES_PUSH),
        .data_i    (shreg_q),
        .ready_i   (out_ready),
        .data_o    (out_data),
        .valid_o   (out_valid),
        .overrun_o (overrun)
    );

    assign par_err   = perr_q;
    assign frame_err = ferr_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_svt_frame_rx.sv
// Bench for svt_frame_rx: directed frames plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_svt_frame_rx;
    import svt_frame_pkg::*;

    localparam int K_NONE = 0;
    localparam int K_PUSH = 1;
    localparam int K_PERR = 2;
    localparam int K_FERR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_en;
    logic       rxd;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       par_err;
    logic       frame_err;
    logic       overrun;
    rx_state_t  state_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int en_phase = 0;

    rx_state_t  drv_next = IDLE;
    int         drv_kind = K_NONE;
    logic [3:0] drv_data = '0;

    logic       m_valid;
    logic [3:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;
    rx_state_t  m_state;
    int         res_kind;
    logic [3:0] res_data;

    svt_frame_rx #(
        .DATA_W     (4),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h want %0h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame's outcome, known from how the bench
    // built it, takes effect one cycle after its stop bit is sampled.
    always @(posedge clk or negedge rst_n) begin : mdl
        logic       nv;
        logic [3:0] nd;
        logic       np;
        logic       nf;
        logic       no;
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_perr   <= 1'b0;
            m_ferr   <= 1'b0;
            m_ovr    <= 1'b0;
            m_state  <= IDLE;
            res_kind <= K_NONE;
            res_data <= '0;
        end else begin
            nv = m_valid;
            nd = m_data;
            np = 1'b0;
            nf = 1'b0;
            no = 1'b0;
            if (res_kind == K_PUSH) begin
                if (m_valid && !out_ready) begin
                    no = 1'b1;
                end else begin
                    nv = 1'b1;
                    nd = res_data;
                end
            end else begin
                np = (res_kind == K_PERR);
                nf = (res_kind == K_FERR);
                if (m_valid && out_ready) nv = 1'b0;
            end
            m_valid <= nv;
            m_data  <= nd;
            m_perr  <= np;
            m_ferr  <= nf;
            m_ovr   <= no;
            if (bit_en) begin
                m_state  <= drv_next;
                res_kind <= drv_kind;
                res_data <= drv_data;
            end else begin
                res_kind <= K_NONE;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("par_err", 32'(par_err), 32'(m_perr));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("state_o", 32'(state_o), 32'(m_state));
        end
    end

    // en_pct 0 selects a fixed one-in-three strobe pattern.
    task automatic send_bit(input logic b, input rx_state_t ns,
                            input int kind, input logic [3:0] d,
                            input int en_pct, input bit rnd_rdy);
        bit got;
        rxd      = b;
        drv_next = ns;
        drv_kind = kind;
        drv_data = d;
        do begin
            if (en_pct == 0) begin
                bit_en = (en_phase % 3 == 2);
                en_phase++;
            end else begin
                bit_en = ($urandom_range(1, 100) <= en_pct);
            end
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            got = bit_en;
            #1;
        end while (!got);
        bit_en   = 1'b0;
        drv_kind = K_NONE;
    endtask

    task automatic idle(input int n, input int en_pct, input bit rnd_rdy);
        for (int i = 0; i < n; i++) begin
            rxd      = 1'b1;
            drv_next = IDLE;
            drv_kind = K_NONE;
            bit_en   = ($urandom_range(1, 100) <= en_pct);
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input bit bad_par,
                              input bit bad_stop, input int en_pct,
                              input bit rnd_rdy);
        logic pb;
        int   kind;
        pb = (^d) ^ bad_par;
        kind = bad_stop ? K_FERR : (bad_par ? K_PERR : K_PUSH);
        send_bit(1'b0, DATA, K_NONE, d, en_pct, rnd_rdy);
        for (int i = 0; i < 4; i++)
            send_bit(d[i], (i == 3) ? PARITY : DATA, K_NONE, d,
                     en_pct, rnd_rdy);
        send_bit(pb, STOP, K_NONE, d, en_pct, rnd_rdy);
        send_bit(~bad_stop, IDLE, kind, d, en_pct, rnd_rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bit_en    = 1'b0;
        rxd       = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_state", 32'(state_o), 32'(IDLE));
        chk("rst_errs", 32'({par_err, frame_err, overrun}), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2, 100, 1'b0);

        // Frame 0xA: bits 0,0,1,0,1,0,1
        send_frame(4'hA, 1'b0, 1'b0, 100, 1'b0);
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        idle(1, 100, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA);
        chk("t1_errs", 32'({par_err, frame_err, overrun}), 32'd0);

        send_frame(4'h3, 1'b0, 1'b0, 100, 1'b0);
        idle(1, 100, 1'b0);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_data_held", 32'(out_data), 32'hA);
        idle(1, 100, 1'b0);
        chk("t4_ovr_pulse", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        idle(1, 100, 1'b0);
        chk("t4_drained", 32'(out_valid), 32'd0);
        chk("t4_data_kept", 32'(out_data), 32'hA);

        send_frame(4'h5, 1'b1, 1'b0, 100, 1'b0);
        idle(1, 100, 1'b0);
        chk("t2_par_err", 32'(par_err), 32'd1);
        chk("t2_valid", 32'(out_valid), 32'd0);
        chk("t2_state", 32'(state_o), 32'(IDLE));
        idle(1, 100, 1'b0);
        chk("t2_pulse", 32'(par_err), 32'd0);

        send_frame(4'h3, 1'b0, 1'b1, 100, 1'b0);
        idle(1, 100, 1'b0);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_par_quiet", 32'(par_err), 32'd0);
        out_ready = 1'b0;
        send_frame(4'h6, 1'b0, 1'b0, 100, 1'b0);
        idle(1, 100, 1'b0);
        chk("t3_good_data", 32'(out_data), 32'h6);
        chk("t3_good_valid", 32'(out_valid), 32'd1);

        // Abort after the start bit and two data bits.
        send_bit(1'b0, DATA, K_NONE, 4'h0, 100, 1'b0);
        send_bit(1'b1, DATA, K_NONE, 4'h0, 100, 1'b0);
        send_bit(1'b0, DATA, K_NONE, 4'h0, 100, 1'b0);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        chk("t5_state", 32'(state_o), 32'(IDLE));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(1, 100, 1'b0);
        send_frame(4'h3, 1'b0, 1'b0, 100, 1'b0);
        idle(1, 100, 1'b0);
        chk("t5_data_after", 32'(out_data), 32'h3);
        out_ready = 1'b1;
        idle(2, 100, 1'b0);

        send_frame(4'hC, 1'b0, 1'b0, 0, 1'b0);
        idle(1, 100, 1'b0);
        chk("t6_data_c", 32'(out_data), 32'hC);
        chk("t6_valid_c", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        send_frame(4'h9, 1'b0, 1'b0, 100, 1'b0);
        out_ready = 1'b1;
        idle(1, 100, 1'b0);
        chk("t6_data_9", 32'(out_data), 32'h9);
        chk("t6_valid_9", 32'(out_valid), 32'd1);
        chk("t6_no_ovr", 32'(overrun), 32'd0);
        idle(2, 100, 1'b0);

        for (int f = 0; f < 80; f++) begin
            send_frame(4'($urandom_range(0, 15)),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0),
                       $urandom_range(30, 100), 1'b1);
            idle($urandom_range(0, 3), $urandom_range(30, 100), 1'b1);
        end
        out_ready = 1'b1;
        idle(4, 100, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
